// File: rtl/sram_burst_pkg.sv
// Shared types and constants for the SRAM burst controller.
// Optional wrapping bursts are enabled with SRAM_BURST_WRAP_EN.
package sram_burst_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        RD_DRAIN = 2'd3
    } state_e;

    localparam int ADDR_WIDTH_DFLT = 16;
    localparam int DATA_WIDTH_DFLT = 8;
    localparam int LEN_WIDTH_DFLT  = 4;

    // The counter holds beats-remaining-minus-one, so it never needs more bits than req_len.
    function automatic int beat_cnt_width(input int len_width);
        return len_width;
    endfunction

    localparam int BEAT_CNT_W_DFLT = beat_cnt_width(LEN_WIDTH_DFLT);

endpackage

// File: rtl/sram_burst_addr_gen.sv
// Loadable burst address register with increment enable.
// With SRAM_BURST_WRAP_EN a captured wrap flag confines increments to the low LEN_WIDTH bits.
module sram_burst_addr_gen
    import sram_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int LEN_WIDTH  = LEN_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
`ifdef SRAM_BURST_WRAP_EN
    input  logic                  load_wrap_i,
`endif
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] addr_inc;

`ifdef SRAM_BURST_WRAP_EN
    logic                 wrap_q, wrap_d;
    logic [LEN_WIDTH-1:0] low_inc;

    assign low_inc  = addr_q[LEN_WIDTH-1:0] + LEN_WIDTH'(1);
    assign addr_inc = wrap_q ? {addr_q[ADDR_WIDTH-1:LEN_WIDTH], low_inc}
                             : addr_q + ADDR_WIDTH'(1);

    always_comb begin
        wrap_d = wrap_q;
        if (load_i) begin
            wrap_d = load_wrap_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end
`else
    assign addr_inc = addr_q + ADDR_WIDTH'(1);
`endif

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_addr_i;
        end else if (inc_i) begin
            addr_d = addr_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst sequencer in front of a single-port synchronous SRAM (one-cycle read latency).
// Define SRAM_BURST_WRAP_EN to add the req_wrap port for aligned wrapping bursts.
//
//   state    | meaning
//   IDLE     | ready for a command, no SRAM activity
//   WR_BURST | one SRAM write per accepted write beat
//   RD_BURST | one SRAM read issued every cycle
//   RD_DRAIN | final read beat returns, done pulses
module sram_burst_ctrl
    import sram_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int LEN_WIDTH  = LEN_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
`ifdef SRAM_BURST_WRAP_EN
    input  logic                  req_wrap,
`endif
    input  logic                  wdata_valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ready,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_wren,
    output logic                  sram_rden,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wr_data,
    input  logic [DATA_WIDTH-1:0] sram_rd_data
);

    localparam int CntW = beat_cnt_width(LEN_WIDTH);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              rvalid_q;
    logic              rlast_q, rlast_d;
    logic              idle_ready;
    logic              addr_load;
    logic              addr_inc;

    sram_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rstn        (rstn),
        .load_i      (addr_load),
        .load_addr_i (req_addr),
`ifdef SRAM_BURST_WRAP_EN
        .load_wrap_i (req_wrap),
`endif
        .inc_i       (addr_inc),
        .addr_o      (sram_addr)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        rlast_d      = 1'b0;
        idle_ready   = 1'b0;
        addr_load    = 1'b0;
        addr_inc     = 1'b0;
        wdata_ready  = 1'b0;
        sram_wren    = 1'b0;
        sram_rden    = 1'b0;
        sram_wr_data = '0;

        case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (req_valid) begin
                    addr_load = 1'b1;
                    cnt_d     = CntW'(req_len);
                    state_d   = req_write ? WR_BURST : RD_BURST;
                end
            end
            WR_BURST: begin
                wdata_ready  = 1'b1;
                sram_wren    = wdata_valid;
                sram_wr_data = wdata;
                if (wdata_valid) begin
                    addr_inc = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            RD_BURST: begin
                sram_rden = 1'b1;
                addr_inc  = 1'b1;
                if (cnt_q == '0) begin
                    // The last read returns next cycle, so done lines up with rdata_last.
                    state_d = RD_DRAIN;
                    done_d  = 1'b1;
                    rlast_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RD_DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            rvalid_q <= sram_rden;
            rlast_q  <= rlast_d;
        end
    end

    assign req_ready   = idle_ready & rstn;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign rdata_valid = rvalid_q;
    assign rdata_last  = rlast_q;
    assign rdata       = rvalid_q ? sram_rd_data : '0;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Self-checking bench for sram_burst_ctrl: SRAM model plus an address-level reference memory.
// Build with SRAM_BURST_WRAP_EN defined to also exercise wrapping bursts.
module tb_sram_burst_ctrl;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [3:0]  req_len;
    logic        req_wrap;
    logic        wdata_valid;
    logic [7:0]  wdata;
    logic        wdata_ready;
    logic        rdata_valid;
    logic [7:0]  rdata;
    logic        rdata_last;
    logic        busy;
    logic        done;
    logic        sram_wren;
    logic        sram_rden;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wr_data;
    logic [7:0]  sram_rd_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sram_mem [0:65535];
    logic [7:0] ref_mem  [0:65535];
    logic [7:0] sram_rd_q;

    sram_burst_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
`ifdef SRAM_BURST_WRAP_EN
        .req_wrap     (req_wrap),
`endif
        .wdata_valid  (wdata_valid),
        .wdata        (wdata),
        .wdata_ready  (wdata_ready),
        .rdata_valid  (rdata_valid),
        .rdata        (rdata),
        .rdata_last   (rdata_last),
        .busy         (busy),
        .done         (done),
        .sram_wren    (sram_wren),
        .sram_rden    (sram_rden),
        .sram_addr    (sram_addr),
        .sram_wr_data (sram_wr_data),
        .sram_rd_data (sram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with registered read data
    always @(posedge clk) begin
        if (sram_wren) sram_mem[sram_addr] <= sram_wr_data;
        if (sram_rden) sram_rd_q <= sram_mem[sram_addr];
    end
    assign sram_rd_data = sram_rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) chk("strobe_excl", {31'b0, sram_wren & sram_rden}, 32'd0);
    end

    function automatic logic [15:0] nxt(input logic [15:0] a, input logic [15:0] start, input bit wrap);
        logic [15:0] p;
        p = a + 16'd1;
        if (wrap) return (start & 16'hFFF0) | (p & 16'h000F);
        return p;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous, 1: random gaps, 2: valid pattern 1,0,0,1,1
    task automatic do_write(input logic [15:0] addr, input int len, input int mode,
                            input logic [7:0] base, input bit wrap, output int pulses);
        logic [15:0] a;
        logic [7:0]  d;
        int k, cyc, gaps;
        bit v;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = 4'(len);
        req_wrap = wrap; wdata_valid = 1'b0;
        #2 chk("wr_req_ready", req_ready, 1);
        tick;
        req_valid = 1'b0;
        a = addr; k = 0; cyc = 0; gaps = 0; pulses = 0;
        while (k <= len) begin
            case (mode)
                0: v = 1'b1;
                2: v = !(cyc == 1 || cyc == 2);
                default: v = (gaps >= 4) ? 1'b1 : ($urandom % 3 != 0);
            endcase
            d = base + 8'(k);
            wdata_valid = v;
            wdata = v ? d : 8'($urandom);
            #2;
            chk("wr_wren", sram_wren, v);
            chk("wr_wdata_ready", wdata_ready, 1);
            chk("wr_busy", busy, 1);
            chk("wr_rden", sram_rden, 0);
            chk("wr_done_early", done, 0);
            chk("wr_req_ready_busy", req_ready, 0);
            pulses += int'(sram_wren);
            if (v) begin
                chk("wr_addr", sram_addr, a);
                chk("wr_data", sram_wr_data, d);
                ref_mem[a] = d;
                a = nxt(a, addr, wrap);
                k++;
                gaps = 0;
            end else begin
                gaps++;
            end
            cyc++;
            tick;
        end
        wdata_valid = 1'b0;
        #2;
        chk("wr_done", done, 1);
        chk("wr_req_ready_end", req_ready, 1);
        chk("wr_busy_end", busy, 0);
        chk("wr_wren_end", sram_wren, 0);
    endtask

    task automatic do_read(input logic [15:0] addr, input int len, input bit wrap, input bit hold);
        logic [15:0] a, prev;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = 4'(len);
        req_wrap = wrap; wdata_valid = 1'b0;
        #2 chk("rd_req_ready", req_ready, 1);
        tick;
        if (!hold) req_valid = 1'b0;
        a = addr; prev = addr;
        for (int k = 0; k <= len; k++) begin
            #2;
            chk("rd_rden", sram_rden, 1);
            chk("rd_wren", sram_wren, 0);
            chk("rd_addr", sram_addr, a);
            chk("rd_busy", busy, 1);
            chk("rd_req_ready_busy", req_ready, 0);
            chk("rd_done_early", done, 0);
            chk("rd_last_early", rdata_last, 0);
            chk("rd_valid", rdata_valid, (k > 0));
            if (k > 0) chk("rd_data", rdata, ref_mem[prev]);
            prev = a;
            a = nxt(a, addr, wrap);
            tick;
        end
        #2;
        chk("rd_drain_rden", sram_rden, 0);
        chk("rd_last_valid", rdata_valid, 1);
        chk("rd_last_data", rdata, ref_mem[prev]);
        chk("rd_last", rdata_last, 1);
        chk("rd_done", done, 1);
        chk("rd_drain_req_ready", req_ready, 0);
        tick;
        #2;
        chk("rd_req_ready_end", req_ready, 1);
        chk("rd_busy_end", busy, 0);
        chk("rd_valid_end", rdata_valid, 0);
        chk("rd_done_end", done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [15:0] ra;
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_wrap = 1'b0; wdata_valid = 1'b0; wdata = '0;
        tick; tick;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wren", sram_wren, 0);
        chk("rst_rden", sram_rden, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wr_data", sram_wr_data, 0);
        chk("rst_rvalid", rdata_valid, 0);
        chk("rst_rlast", rdata_last, 0);
        tick;
        rstn = 1'b1;
        #2 chk("rst_req_ready", req_ready, 1);
        tick;

        do_write(16'h0010, 3, 0, 8'hA0, 1'b0, pulses);
        chk("wr_cont_pulses", pulses, 4);
        do_read(16'h0010, 3, 1'b0, 1'b0);

        tick;
        do_write(16'h0040, 2, 2, 8'h30, 1'b0, pulses);
        chk("wr_gap_pulses", pulses, 3);
        do_read(16'h0040, 2, 1'b0, 1'b0);

        do_write(16'hFFFE, 3, 0, 8'hC0, 1'b0, pulses);
        do_read(16'hFFFE, 3, 1'b0, 1'b0);
`ifdef SRAM_BURST_WRAP_EN
        do_write(16'hFFF0, 1, 0, 8'hD0, 1'b0, pulses);
        do_read(16'hFFFE, 3, 1'b1, 1'b0);
`endif

        // Reset in the cycle after the first of four write beats
        tick;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_len = 4'd3; req_wrap = 1'b0;
        tick;
        req_valid = 1'b0;
        wdata_valid = 1'b1; wdata = 8'h5A;
        #2 chk("rst_mid_wren", sram_wren, 1);
        ref_mem[16'h0010] = 8'h5A;
        tick;
        wdata_valid = 1'b0;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        #2;
        chk("rmid_busy", busy, 0);
        chk("rmid_done", done, 0);
        chk("rmid_wren", sram_wren, 0);
        chk("rmid_rden", sram_rden, 0);
        chk("rmid_addr", sram_addr, 0);
        chk("rmid_wr_data", sram_wr_data, 0);
        chk("rmid_wdata_ready", wdata_ready, 0);
        chk("rmid_rvalid", rdata_valid, 0);
        chk("rmid_rlast", rdata_last, 0);
        chk("rmid_req_ready", req_ready, 1);
        tick;
        #2 chk("rmid_done_after", done, 0);
        do_read(16'h0010, 3, 1'b0, 1'b0);

        // Single-beat read with req_valid held, then an immediate second command
        do_read(16'h0011, 0, 1'b0, 1'b1);
        do_read(16'h0012, 1, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            bit w;
            int l;
            tick;
            ra = ($urandom % 4 == 0) ? 16'(16'hFFF8 + ($urandom % 8)) : 16'($urandom % 256);
            l = int'($urandom % 16);
`ifdef SRAM_BURST_WRAP_EN
            w = 1'($urandom % 2);
`else
            w = 1'b0;
`endif
            if ($urandom % 2 == 0) begin
                do_write(ra, l, 1, 8'($urandom), w, pulses);
                chk("rnd_wr_pulses", pulses, l + 1);
            end else begin
                do_read(ra, l, w, 1'b0);
            end
        end

        tick; tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
